// File: rtl/led_pattern_engine.sv
// led_pattern_engine
//   LED pattern generator for the TM1638 LED row. Eight selectable
//   patterns, four step rates, pause, and single-step while paused.
//   Every output is a register; no input has a combinational path out.
//
// Parameters
//   N_LEDS    LED count (2..32)
//   TICK_DIV  clki cycles per step at speed 3 (fastest); speed 0 is 8x slower
//
// Ports
//   clki      in   1       board clock
//   reset     in   1       synchronous, active-high
//   mode      in   3       pattern select (asynchronous switch)
//   speed     in   2       step-rate select (asynchronous switch)
//   sw_pause  in   1       1 = freeze the pattern (asynchronous switch)
//   sw_step   in   1       single-step request, rising edge, only while paused
//   leds      out  N_LEDS  pattern output
//   adv       out  1       one-cycle pulse after each advance or reload
module led_pattern_engine #(
    parameter int N_LEDS   = 8,
    parameter int TICK_DIV = 6250000
) (
    input  logic              clki,
    input  logic              reset,
    input  logic [2:0]        mode,
    input  logic [1:0]        speed,
    input  logic              sw_pause,
    input  logic              sw_step,
    output logic [N_LEDS-1:0] leds,
    output logic              adv
);

    localparam int CNT_W  = $clog2(8 * TICK_DIV);
    localparam int K_W    = $clog2(N_LEDS + 1);
    localparam int SYNC_W = 7;

    // Terminal counts (PER-1) for each speed setting.
    localparam logic [CNT_W-1:0] PER_M1_S0 = CNT_W'(8 * TICK_DIV - 1);
    localparam logic [CNT_W-1:0] PER_M1_S1 = CNT_W'(4 * TICK_DIV - 1);
    localparam logic [CNT_W-1:0] PER_M1_S2 = CNT_W'(2 * TICK_DIV - 1);
    localparam logic [CNT_W-1:0] PER_M1_S3 = CNT_W'(TICK_DIV - 1);
    localparam logic [K_W-1:0]   K_MAX     = K_W'(N_LEDS);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    // Two-stage synchroniser for all switch inputs, packed {mode, speed, pause, step}.
    logic [SYNC_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic              step_d_q, step_d_d;
    logic [2:0]        mode_s;
    logic [1:0]        speed_s;
    logic              pause_s, step_s;

    logic [2:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_LEDS-1:0] leds_q, leds_d;
    logic [K_W-1:0]    k_q, k_d;
    dir_t              dir_q, dir_d;
    logic              adv_q, adv_d;

    logic [CNT_W-1:0]  per_m1;
    logic              tick, step_rise, advance, reload;
    logic [N_LEDS-1:0] seed_v, pat_next, bar_next, check_seed;
    logic [K_W-1:0]    k_step, k_next;
    dir_t              dir_next;

    assign {mode_s, speed_s, pause_s, step_s} = sync2_q;

    assign step_rise = step_s & ~step_d_q;
    assign tick      = (cnt_q >= per_m1);
    assign advance   = (tick & ~pause_s) | (step_rise & pause_s);
    assign reload    = (mode_s != mode_q);

    // BAR: bit gi is lit when gi < k, giving (1<<k)-1 without overflowing at k=N.
    assign k_step = (k_q == K_MAX) ? '0 : k_q + K_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < N_LEDS; gi++) begin : g_bits
            assign bar_next[gi]   = (k_step > K_W'(gi));
            assign check_seed[gi] = ((gi % 2) == 0);
        end
    endgenerate

    always_comb begin
        per_m1 = PER_M1_S3;
        case (speed_s)
            2'd0:    per_m1 = PER_M1_S0;
            2'd1:    per_m1 = PER_M1_S1;
            2'd2:    per_m1 = PER_M1_S2;
            default: per_m1 = PER_M1_S3;
        endcase
    end

    always_comb begin
        seed_v = '0;
        case (mode_s)
            3'd0:    seed_v = N_LEDS'(1);
            3'd1:    seed_v = {1'b1, {(N_LEDS-1){1'b0}}};
            3'd2:    seed_v = N_LEDS'(1);
            3'd6:    seed_v = check_seed;
            default: seed_v = '0;
        endcase
    end

    // Per-advance update for the currently loaded mode.
    always_comb begin
        pat_next = leds_q;
        dir_next = dir_q;
        k_next   = k_q;
        case (mode_q)
            3'd0: pat_next = {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
            3'd1: pat_next = {leds_q[0], leds_q[N_LEDS-1:1]};
            3'd2: begin
                // The end bit turns around within the same advance, so the
                // ends are never shown twice in a row.
                if (dir_q == DIR_UP) begin
                    if (leds_q[N_LEDS-1]) begin
                        dir_next = DIR_DOWN;
                        pat_next = leds_q >> 1;
                    end else begin
                        pat_next = leds_q << 1;
                    end
                end else begin
                    if (leds_q[0]) begin
                        dir_next = DIR_UP;
                        pat_next = leds_q << 1;
                    end else begin
                        pat_next = leds_q >> 1;
                    end
                end
            end
            3'd3: begin
                k_next   = k_step;
                pat_next = bar_next;
            end
            3'd4:    pat_next = ~leds_q;
            3'd5:    pat_next = leds_q + N_LEDS'(1);
            3'd6:    pat_next = ~leds_q;
            default: pat_next = '0;
        endcase
    end

    always_comb begin
        sync1_d  = {mode, speed, sw_pause, sw_step};
        sync2_d  = sync1_q;
        step_d_d = step_s;
        mode_d   = mode_q;
        leds_d   = leds_q;
        k_d      = k_q;
        dir_d    = dir_q;
        adv_d    = 1'b0;

        // Pause holds the count so an unpause resumes mid-period.
        if (pause_s) begin
            cnt_d = cnt_q;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A reload swallows any advance due in the same cycle.
        if (reload) begin
            mode_d = mode_s;
            leds_d = seed_v;
            k_d    = '0;
            dir_d  = DIR_UP;
            cnt_d  = '0;
            adv_d  = 1'b1;
        end else if (advance) begin
            leds_d = pat_next;
            k_d    = k_next;
            dir_d  = dir_next;
            adv_d  = 1'b1;
        end
    end

    always_ff @(posedge clki) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            step_d_q <= 1'b0;
            mode_q   <= 3'd0;
            cnt_q    <= '0;
            leds_q   <= N_LEDS'(1);
            k_q      <= '0;
            dir_q    <= DIR_UP;
            adv_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            step_d_q <= step_d_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            leds_q   <= leds_d;
            k_q      <= k_d;
            dir_q    <= dir_d;
            adv_q    <= adv_d;
        end
    end

    assign leds = leds_q;
    assign adv  = adv_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine
//   Directed bench for led_pattern_engine with N_LEDS=8, TICK_DIV=4.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_led_pattern_engine;

    logic       clki;
    logic       reset;
    logic [2:0] mode;
    logic [1:0] speed;
    logic       sw_pause;
    logic       sw_step;
    logic [7:0] leds;
    logic       adv;

    int total;
    int bad;

    led_pattern_engine #(.N_LEDS(8), .TICK_DIV(4)) dut (
        .clki     (clki),
        .reset    (reset),
        .mode     (mode),
        .speed    (speed),
        .sw_pause (sw_pause),
        .sw_step  (sw_step),
        .leds     (leds),
        .adv      (adv)
    );

    initial clki = 1'b0;
    always #5 clki = ~clki;

    task automatic tick();
        @(posedge clki);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Cycles until the next adv pulse; -1 if none within 64 cycles.
    task automatic wait_adv(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (adv !== 1'b1 && n < 64);
        if (adv !== 1'b1) n = -1;
    endtask

    task automatic count_adv(input int cycles, output int advs);
        advs = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (adv === 1'b1) advs++;
        end
    endtask

    initial begin
        logic [7:0] rot_exp [7];
        logic [7:0] bnc_exp [15];
        logic [7:0] bar_exp [9];
        logic [2:0] tbl_mode [3];
        logic [7:0] tbl_seed [3];
        logic [7:0] tbl_next [3];
        int         n;
        int         advs;
        int         changes;
        logic [7:0] held;

        rot_exp = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        bnc_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                    8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        bar_exp = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
        tbl_mode = '{3'd1, 3'd4, 3'd7};
        tbl_seed = '{8'h80, 8'h00, 8'h00};
        tbl_next = '{8'h40, 8'hFF, 8'h00};

        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        mode     = 3'd0;
        speed    = 2'd3;
        sw_pause = 1'b0;
        sw_step  = 1'b0;

        // 1: reset state, then ROTL at speed 3
        repeat (3) tick();
        chk("rst_leds", 32'(leds), 32'h01);
        chk("rst_adv", 32'(adv), 32'h0);
        reset = 1'b0;
        wait_adv(n);
        chk("rotl_first_n", 32'(n), 32'd4);
        chk("rotl_first", 32'(leds), 32'h02);
        for (int i = 0; i < 7; i++) begin
            wait_adv(n);
            chk("rotl_n", 32'(n), 32'd4);
            chk("rotl_leds", 32'(leds), 32'(rot_exp[i]));
        end
        tick();
        chk("adv_one_cycle", 32'(adv), 32'h0);
        wait_adv(n);

        // 2: BOUNCE; reload 3 cycles after the mode input changes
        mode = 3'd2;
        wait_adv(n);
        chk("bnc_reload_n", 32'(n), 32'd3);
        chk("bnc_seed", 32'(leds), 32'h01);
        for (int i = 0; i < 15; i++) begin
            wait_adv(n);
            chk("bnc_n", 32'(n), 32'd4);
            chk("bnc_leds", 32'(leds), 32'(bnc_exp[i]));
        end

        // 3: BAR, then COUNT wrapping through 2^8
        mode = 3'd3;
        wait_adv(n);
        chk("bar_reload_n", 32'(n), 32'd3);
        chk("bar_seed", 32'(leds), 32'h00);
        for (int i = 0; i < 9; i++) begin
            wait_adv(n);
            chk("bar_leds", 32'(leds), 32'(bar_exp[i]));
        end
        mode = 3'd5;
        wait_adv(n);
        chk("cnt_seed", 32'(leds), 32'h00);
        for (int i = 1; i <= 256; i++) begin
            wait_adv(n);
            chk("cnt_leds", 32'(leds), 32'(i % 256));
        end

        // 4: speed 0 period, then a speed raise late in the count
        mode = 3'd0;
        wait_adv(n);
        chk("rotl_reload", 32'(leds), 32'h01);
        speed = 2'd0;
        wait_adv(n);
        chk("spd0_n", 32'(n), 32'd32);
        chk("spd0_leds", 32'(leds), 32'h02);
        wait_adv(n);
        chk("spd0_n2", 32'(n), 32'd32);
        chk("spd0_leds2", 32'(leds), 32'h04);
        repeat (18) tick();
        speed = 2'd3;
        wait_adv(n);
        chk("spdup_n", 32'(n), 32'd3);
        chk("spdup_leds", 32'(leds), 32'h08);
        wait_adv(n);
        chk("spd3_n", 32'(n), 32'd4);
        chk("spd3_leds", 32'(leds), 32'h10);

        // 5: pause, single steps, held step, resume from held count
        sw_pause = 1'b1;
        held     = leds;
        changes  = 0;
        advs     = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (leds !== held) changes++;
            if (adv === 1'b1) advs++;
        end
        chk("pause_changes", 32'(changes), 32'd0);
        chk("pause_advs", 32'(advs), 32'd0);
        n = 0;
        for (int p = 0; p < 3; p++) begin
            sw_step = 1'b1;
            count_adv(2, advs);
            n += advs;
            sw_step = 1'b0;
            count_adv(4, advs);
            n += advs;
        end
        chk("step3_advs", 32'(n), 32'd3);
        chk("step3_leds", 32'(leds), 32'h80);
        sw_step = 1'b1;
        count_adv(20, advs);
        chk("step_held_advs", 32'(advs), 32'd1);
        chk("step_held_leds", 32'(leds), 32'h01);
        sw_step = 1'b0;
        count_adv(6, advs);
        chk("step_rel_advs", 32'(advs), 32'd0);
        sw_pause = 1'b0;
        wait_adv(n);
        chk("unpause_n", 32'(n), 32'd4);
        chk("unpause_leds", 32'(leds), 32'h02);

        // 6a: mode change lands on the cycle a tick is due
        tick();
        mode = 3'd6;
        wait_adv(n);
        chk("chk_reload_n", 32'(n), 32'd3);
        chk("chk_seed", 32'(leds), 32'h55);
        wait_adv(n);
        chk("chk_after_n", 32'(n), 32'd4);
        chk("chk_next", 32'(leds), 32'hAA);

        // Remaining seeds and first steps
        for (int m = 0; m < 3; m++) begin
            mode = tbl_mode[m];
            wait_adv(n);
            chk("tbl_reload_n", 32'(n), 32'd3);
            chk("tbl_seed", 32'(leds), 32'(tbl_seed[m]));
            wait_adv(n);
            chk("tbl_step_n", 32'(n), 32'd4);
            chk("tbl_next", 32'(leds), 32'(tbl_next[m]));
        end

        // 6b: reset while BOUNCE is moving down
        mode = 3'd2;
        wait_adv(n);
        chk("bnc2_seed", 32'(leds), 32'h01);
        repeat (8) wait_adv(n);
        chk("bnc2_down", 32'(leds), 32'h40);
        reset = 1'b1;
        tick();
        chk("mid_rst_leds", 32'(leds), 32'h01);
        chk("mid_rst_adv", 32'(adv), 32'h0);
        reset = 1'b0;
        wait_adv(n);
        chk("post_rst_n", 32'(n), 32'd3);
        chk("post_rst_leds", 32'(leds), 32'h01);
        wait_adv(n);
        chk("post_rst_up_n", 32'(n), 32'd4);
        chk("post_rst_up", 32'(leds), 32'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
